// File: rtl/comb_monitor_pkg.sv
// comb_monitor_pkg: state type and default parameters shared by the change monitor
package comb_monitor_pkg;
   typedef enum logic {INIT, RUN} state_t;
   localparam int DEF_CHANNELS = 2;
   localparam int DEF_WIDTH    = 1;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_TS_WIDTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock record FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [DW-1:0]                i_data,
   output logic [DW-1:0]                o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          w_wr;
   logic          w_rd;
   assign o_empty = r_count == '0;
   assign o_full  = r_count == CW'(DEPTH);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd];
   assign w_rd    = i_pop && !o_empty;
   assign w_wr    = i_push && (!o_full || w_rd);
   always_ff @(posedge clk) begin
      if (w_wr && !rst) r_mem[r_wr] <= i_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wr <= r_wr + 1'b1;
         if (w_rd) r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end
endmodule

// File: rtl/comb_change_monitor.sv
// comb_change_monitor: records {in_data, timestamp} at start-up and on every input change
module comb_change_monitor
   import comb_monitor_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int TS_WIDTH = DEF_TS_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*WIDTH-1:0]    in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*WIDTH-1:0]    out_data,
   output logic [TS_WIDTH-1:0]          out_time,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int DW = CHANNELS*WIDTH;
   state_t                       r_state;
   logic [TS_WIDTH-1:0]          r_ts;
   logic [DW-1:0]                r_prev;
   logic                         r_overflow;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_full;
   logic                         w_empty;
   logic [DW+TS_WIDTH-1:0]       w_head;
   logic [$clog2(DEPTH+1)-1:0]   w_count;
   // case-inequality so X/Z transitions also count as changes
   assign w_push    = !rst && (r_state == INIT || in_data !== r_prev);
   assign out_valid = !rst && !w_empty;
   assign w_pop     = out_valid && out_ready;
   assign {out_data, out_time} = out_valid ? w_head : '0;
   assign count     = rst ? '0 : w_count;
   assign overflow  = r_overflow;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= INIT;
         r_ts       <= '0;
         r_prev     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= RUN;
         r_ts    <= r_ts + 1'b1;
         r_prev  <= in_data;
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end
   sync_fifo #(.DW(DW+TS_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({in_data, r_ts}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
endmodule
